// File: rtl/cpu_bus_pkg.sv
// Shared types and widths for the multi-beat CPU bus transfer unit.
// Exports: state_e, ADDR_W, REG_W, BUS_W, BEATS, IDX_W, lane_byte().
package cpu_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int REG_W  = 32;
    localparam int BUS_W  = 8;
    localparam int BEATS  = REG_W / BUS_W;
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        RELEASE
    } state_e;

    function automatic logic [BUS_W-1:0] lane_byte(
        input logic [REG_W-1:0] data,
        input logic [IDX_W-1:0] lane
    );
        return data[lane*BUS_W +: BUS_W];
    endfunction

endpackage

// File: rtl/cpu_bus_xfer_if.sv
// Core request/response and external narrow-bus signals of cpu_bus_xfer.
// master: the transfer unit; slave: core plus external memory side.
interface cpu_bus_xfer_if;
    import cpu_bus_pkg::*;

    logic              i_req;
    logic              i_we;
    logic              i_dir;
    logic [ADDR_W-1:0] i_addr;
    logic [IDX_W-1:0]  i_size;
    logic [REG_W-1:0]  i_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [REG_W-1:0]  o_rdata;
    logic              o_bus_clk;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [BUS_W-1:0]  o_bus_data;
    logic [BUS_W-1:0]  i_bus_data;
    logic              i_bus_data_ready;

    modport master (
        input  i_req, i_we, i_dir, i_addr, i_size, i_wdata,
        input  i_bus_data, i_bus_data_ready,
        output o_busy, o_done, o_err, o_rdata,
        output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
    );

    modport slave (
        output i_req, i_we, i_dir, i_addr, i_size, i_wdata,
        output i_bus_data, i_bus_data_ready,
        input  o_busy, o_done, o_err, o_rdata,
        input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
    );

endinterface

// File: rtl/cpu_bus_beat_timer.sv
// Per-beat watchdog: counts enabled cycles since the last clear.
// Ports: i_clk, i_rst, i_clr, i_en, o_expire (high on the TIMEOUT-th cycle).
module cpu_bus_beat_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expire is combinational so the FSM aborts on the edge
    // that completes the TIMEOUT-th cycle of the beat.
    assign o_expire = i_en && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_en && !o_expire)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cpu_bus_xfer.sv
// Sequences one 1..BEATS-beat load/store as strobe/ready handshakes.
// Ports: i_clk, i_rst, bus (cpu_bus_xfer_if.master); CPU_BUS_TIMEOUT_EN adds beat timeout.
module cpu_bus_xfer
    import cpu_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    cpu_bus_xfer_if.master   bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  lane_q, lane_d;
    logic              we_q, we_d;
    logic              dir_q, dir_d;
    logic [REG_W-1:0]  wdata_q, wdata_d;
    logic [REG_W-1:0]  rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              bclk_q, bclk_d;
    logic              bwe_q, bwe_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [BUS_W-1:0]  bdata_q, bdata_d;

    logic              tmr_clr;
    logic              tmr_en;
    logic              expire;
    logic [IDX_W-1:0]  lane_nx;

    assign tmr_en = (state_q != IDLE);

`ifdef CPU_BUS_TIMEOUT_EN
    cpu_bus_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (tmr_clr),
        .i_en     (tmr_en),
        .o_expire (expire)
    );
`else
    wire unused_timer = tmr_clr ^ tmr_en ^ (TIMEOUT != 0);
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        lane_d  = lane_q;
        we_d    = we_q;
        dir_d   = dir_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        bclk_d  = bclk_q;
        bwe_d   = bwe_q;
        baddr_d = baddr_q;
        bdata_d = bdata_q;
        tmr_clr = 1'b0;
        lane_nx = dir_q ? lane_q - 1'b1 : lane_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req) begin
                    lane_d  = bus.i_dir ? bus.i_size : '0;
                    state_d = STROBE;
                    k_d     = '0;
                    last_d  = bus.i_size;
                    we_d    = bus.i_we;
                    dir_d   = bus.i_dir;
                    wdata_d = bus.i_wdata;
                    rdata_d = '0;
                    busy_d  = 1'b1;
                    bclk_d  = 1'b1;
                    bwe_d   = bus.i_we;
                    baddr_d = bus.i_addr;
                    bdata_d = lane_byte(bus.i_wdata, lane_d);
                    tmr_clr = 1'b1;
                end
            end
            STROBE: begin
                if (expire) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    bclk_d  = 1'b0;
                    bwe_d   = 1'b0;
                end else if (bus.i_bus_data_ready) begin
                    if (!we_q)
                        rdata_d[lane_q*BUS_W +: BUS_W] = bus.i_bus_data;
                    state_d = RELEASE;
                    bclk_d  = 1'b0;
                end
            end
            RELEASE: begin
                if (expire) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    bwe_d   = 1'b0;
                end else if (!bus.i_bus_data_ready) begin
                    if (k_q != last_q) begin
                        state_d = STROBE;
                        k_d     = k_q + 1'b1;
                        lane_d  = lane_nx;
                        bclk_d  = 1'b1;
                        baddr_d = dir_q ? baddr_q - 1'b1
                                        : baddr_q + 1'b1;
                        bdata_d = lane_byte(wdata_q, lane_nx);
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        bwe_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            last_q  <= '0;
            lane_q  <= '0;
            we_q    <= 1'b0;
            dir_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bclk_q  <= 1'b0;
            bwe_q   <= 1'b0;
            baddr_q <= '0;
            bdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            dir_q   <= dir_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bclk_q  <= bclk_d;
            bwe_q   <= bwe_d;
            baddr_q <= baddr_d;
            bdata_q <= bdata_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_rdata    = rdata_q;
    assign bus.o_bus_clk  = bclk_q;
    assign bus.o_bus_we   = bwe_q;
    assign bus.o_bus_addr = baddr_q;
    assign bus.o_bus_data = bdata_q;

endmodule

// File: tb/tb_cpu_bus_xfer.sv
// Directed bench for cpu_bus_xfer with a wait-state capable byte slave.
// Vector table plus back-to-back, reset and (optional) timeout sequences.
module tb_cpu_bus_xfer;
    import cpu_bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_bus_xfer_if bif ();

    cpu_bus_xfer #(
        .TIMEOUT (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif.master)
    );

    typedef struct {
        logic        we;
        logic        dir;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          wait0;
        logic [31:0] exp_rdata;
        int          exp_cyc;
        logic [31:0] exp_a0;
        logic [31:0] exp_alast;
        logic [7:0]  exp_d0;
        logic [7:0]  exp_dlast;
    } vec_t;

    int total = 0;
    int bad = 0;

    logic [7:0]  rmem [256];
    int          cur_wait = 0;
    int          sc = 0;
    bit          never = 0;
    logic [31:0] log_addr [$];
    logic [7:0]  log_data [$];
    logic        log_we [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Slave: updates ready 1ns after each edge from the registered strobe.
    initial begin
        bif.i_bus_data_ready = 1'b0;
        bif.i_bus_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bif.o_bus_clk) begin
                if (!never && sc >= cur_wait) begin
                    if (!bif.i_bus_data_ready) begin
                        log_addr.push_back(bif.o_bus_addr);
                        log_data.push_back(bif.o_bus_data);
                        log_we.push_back(bif.o_bus_we);
                    end
                    bif.i_bus_data = rmem[bif.o_bus_addr[7:0]];
                    bif.i_bus_data_ready = 1'b1;
                    cur_wait = 0;
                end else begin
                    bif.i_bus_data_ready = 1'b0;
                end
                sc++;
            end else begin
                bif.i_bus_data_ready = 1'b0;
                sc = 0;
            end
        end
    end

    task automatic start(vec_t v);
        @(negedge clk);
        bif.i_req = 1'b1;
        bif.i_we = v.we;
        bif.i_dir = v.dir;
        bif.i_addr = v.addr;
        bif.i_size = v.size;
        bif.i_wdata = v.wdata;
        cur_wait = v.wait0;
        log_addr.delete();
        log_data.delete();
        log_we.delete();
    endtask

    // Returns cycles from the acceptance edge to the o_done cycle.
    task automatic wait_done(output int cyc, output bit ok,
                             input bit drop);
        ok = 0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            cyc++;
            if (bif.o_done) begin
                ok = 1;
                break;
            end
        end
        if (drop)
            bif.i_req = 1'b0;
    endtask

    task automatic run_vec(vec_t v, int idx);
        int cyc;
        bit ok;
        start(v);
        @(posedge clk);
        #2;
        chk($sformatf("v%0d busy", idx), 32'(bif.o_busy), 32'd1);
        wait_done(cyc, ok, 1'b1);
        chk($sformatf("v%0d done_seen", idx), 32'(ok), 32'd1);
        chk($sformatf("v%0d cycles", idx), cyc, v.exp_cyc);
        chk($sformatf("v%0d err", idx), 32'(bif.o_err), 32'd0);
        chk($sformatf("v%0d busy_end", idx), 32'(bif.o_busy), 32'd0);
        chk($sformatf("v%0d rdata", idx), bif.o_rdata, v.exp_rdata);
        chk($sformatf("v%0d beats", idx), log_addr.size(),
            32'(v.size) + 1);
        if (log_addr.size() > 0) begin
            chk($sformatf("v%0d addr0", idx), log_addr[0], v.exp_a0);
            chk($sformatf("v%0d addrN", idx), log_addr[$], v.exp_alast);
            chk($sformatf("v%0d data0", idx), 32'(log_data[0]),
                32'(v.exp_d0));
            chk($sformatf("v%0d dataN", idx), 32'(log_data[$]),
                32'(v.exp_dlast));
            chk($sformatf("v%0d we0", idx), 32'(log_we[0]), 32'(v.we));
            chk($sformatf("v%0d weN", idx), 32'(log_we[$]), 32'(v.we));
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " busy"}, 32'(bif.o_busy), 0);
        chk({tag, " done"}, 32'(bif.o_done), 0);
        chk({tag, " err"}, 32'(bif.o_err), 0);
        chk({tag, " rdata"}, bif.o_rdata, 0);
        chk({tag, " bus_clk"}, 32'(bif.o_bus_clk), 0);
        chk({tag, " bus_we"}, 32'(bif.o_bus_we), 0);
        chk({tag, " bus_addr"}, bif.o_bus_addr, 0);
        chk({tag, " bus_data"}, 32'(bif.o_bus_data), 0);
    endtask

    vec_t vt [8];
    vec_t vx;
    int   cyc;
    bit   ok;

    initial begin
        for (int i = 0; i < 256; i++)
            rmem[i] = 8'h00;
        rmem[8'h34] = 8'hA5;
        rmem[8'h00] = 8'h11;
        rmem[8'h01] = 8'h22;
        rmem[8'h02] = 8'h33;
        rmem[8'h03] = 8'h44;
        rmem[8'hFF] = 8'h5C;

        //         we dir addr          sz wdata         w  rdata         cyc a0            alast         d0     dN
        vt[0] = '{1'b0, 1'b0, 32'h0000_1234, 2'd0, 32'h0, 0,
                  32'h0000_00A5, 2, 32'h0000_1234, 32'h0000_1234, 8'h00, 8'h00};
        vt[1] = '{1'b0, 1'b0, 32'h0000_2000, 2'd3, 32'h0, 0,
                  32'h4433_2211, 8, 32'h0000_2000, 32'h0000_2003, 8'h00, 8'h00};
        vt[2] = '{1'b1, 1'b1, 32'h0000_01FF, 2'd1, 32'h0000_BEEF, 0,
                  32'h0, 4, 32'h0000_01FF, 32'h0000_01FE, 8'hBE, 8'hEF};
        vt[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0, 3,
                  32'h0000_115C, 7, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00, 8'h00};
        vt[4] = '{1'b0, 1'b1, 32'h0000_0001, 2'd2, 32'h0, 0,
                  32'h0022_115C, 6, 32'h0000_0001, 32'hFFFF_FFFF, 8'h00, 8'h00};
        vt[5] = '{1'b1, 1'b0, 32'h0000_0010, 2'd3, 32'hCAFE_F00D, 0,
                  32'h0, 8, 32'h0000_0010, 32'h0000_0013, 8'h0D, 8'hCA};
        vt[6] = '{1'b1, 1'b1, 32'h0000_0000, 2'd0, 32'h1234_5678, 2,
                  32'h0, 4, 32'h0000_0000, 32'h0000_0000, 8'h78, 8'h78};
        vt[7] = '{1'b0, 1'b1, 32'h0000_0003, 2'd3, 32'h0, 1,
                  32'h4433_2211, 9, 32'h0000_0003, 32'h0000_0000, 8'h00, 8'h00};

        bif.i_req = 1'b0;
        bif.i_we = 1'b0;
        bif.i_dir = 1'b0;
        bif.i_addr = '0;
        bif.i_size = '0;
        bif.i_wdata = '0;

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_vec(vt[i], i);

        // Back-to-back: next request held high through the o_done cycle.
        start(vt[0]);
        @(posedge clk);
        wait_done(cyc, ok, 1'b0);
        chk("b2b first_done", 32'(ok), 1);
        bif.i_addr = 32'h0000_2000;
        @(posedge clk);
        #2;
        chk("b2b busy", 32'(bif.o_busy), 1);
        chk("b2b bus_clk", 32'(bif.o_bus_clk), 1);
        chk("b2b bus_addr", bif.o_bus_addr, 32'h0000_2000);
        chk("b2b rdata_clr", bif.o_rdata, 0);
        wait_done(cyc, ok, 1'b1);
        chk("b2b cycles", cyc, 2);
        chk("b2b rdata", bif.o_rdata, 32'h0000_0011);

        // Reset while the third beat is strobing.
        start(vt[1]);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (bif.o_bus_clk && log_addr.size() == 3) begin
                ok = 1;
                break;
            end
        end
        chk("rst reach_beat2", 32'(ok), 1);
        bif.i_req = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            chk("midrst no_done", 32'(bif.o_done | bif.o_busy), 0);
        end
        run_vec(vt[0], 10);

`ifdef CPU_BUS_TIMEOUT_EN
        never = 1;
        vx = vt[0];
        start(vx);
        @(posedge clk);
        wait_done(cyc, ok, 1'b1);
        chk("tmo done_seen", 32'(ok), 1);
        chk("tmo cycles", cyc, 16);
        chk("tmo err", 32'(bif.o_err), 1);
        chk("tmo bus_clk", 32'(bif.o_bus_clk), 0);
        never = 0;
        @(posedge clk);
        #2;
        chk("tmo err_pulse", 32'(bif.o_err), 0);
        run_vec(vt[1], 11);
`else
        vx = vt[0];
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
